// File: rtl/bit_serializer.sv
// bit_serializer: valid/ready parallel word in, MSB-first serial out on negedge ck.
// Optional SER_PARITY_EN appends an even-parity bit after each word.
module bit_serializer #(
  parameter int WIDTH = 8,
  parameter int GAP = 0
) (
  input  logic             ck,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_vld,
  output logic             din_rdy,
  output logic             so,
  output logic             so_vld,
  output logic             busy,
  output logic             done
);
`ifdef SER_PARITY_EN
  localparam int SW = WIDTH + 1;
`else
  localparam int SW = WIDTH;
`endif
  localparam int CW = $clog2(SW);
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;
  state_t state, state_nxt;
  logic [SW-1:0] sr, sr_nxt, word;
  logic [CW-1:0] bcnt, bcnt_nxt;
  logic [3:0] gcnt, gcnt_nxt;
  logic last, take;
`ifdef SER_PARITY_EN
  assign word = {din, ^din};
`else
  assign word = din;
`endif
  assign last = state == S_SHIFT && bcnt == '0;
  assign din_rdy = rst_n && (state == S_IDLE || (GAP == 0 && last));
  assign take = din_vld && din_rdy;
  assign done = last;
  assign busy = state != S_IDLE;
  // shifting in zeros leaves sr clear once a word is out, so so needs no gating
  assign so = sr[SW-1];
  always_comb begin
    state_nxt = state;
    sr_nxt = sr;
    bcnt_nxt = bcnt;
    gcnt_nxt = gcnt;
    case (state)
      S_IDLE: if (take) begin
        state_nxt = S_SHIFT;
        sr_nxt = word;
        bcnt_nxt = CW'(SW - 1);
      end
      S_SHIFT: begin
        sr_nxt = {sr[SW-2:0], 1'b0};
        bcnt_nxt = bcnt - 1'b1;
        if (last) begin
          if (GAP > 0) begin
            state_nxt = S_GAP;
            gcnt_nxt = 4'(GAP - 1);
            bcnt_nxt = '0;
          end else if (take) begin
            sr_nxt = word;
            bcnt_nxt = CW'(SW - 1);
          end else begin
            state_nxt = S_IDLE;
            bcnt_nxt = '0;
          end
        end
      end
      S_GAP: begin
        gcnt_nxt = gcnt - 1'b1;
        if (gcnt == '0) begin
          state_nxt = S_IDLE;
          gcnt_nxt = '0;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end
  always_ff @(negedge ck or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      sr <= '0;
      bcnt <= '0;
      gcnt <= '0;
      so_vld <= 1'b0;
    end else begin
      state <= state_nxt;
      sr <= sr_nxt;
      bcnt <= bcnt_nxt;
      gcnt <= gcnt_nxt;
      so_vld <= state_nxt == S_SHIFT;
    end
  end
endmodule

// File: tb/tb_bit_serializer.sv
// tb_bit_serializer: two instances (GAP=0 and GAP=3) checked each cycle
// against a queue of expected serial-stream entries.
module tb_bit_serializer;
`ifdef SER_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  typedef struct packed {logic b; logic v; logic l;} ent_t;
  logic ck = 1'b1, rst_n = 1'b0, din_vld = 1'b0;
  logic [7:0] din = '0;
  logic [1:0] rdy, so, sov, bsy, dn;
  ent_t q[2][$];
  int checks = 0, failures = 0;

  always #5 ck = ~ck;

  bit_serializer #(.WIDTH(8), .GAP(0)) u0 (.ck(ck), .rst_n(rst_n), .din(din), .din_vld(din_vld),
    .din_rdy(rdy[0]), .so(so[0]), .so_vld(sov[0]), .busy(bsy[0]), .done(dn[0]));
  bit_serializer #(.WIDTH(8), .GAP(3)) u1 (.ck(ck), .rst_n(rst_n), .din(din), .din_vld(din_vld),
    .din_rdy(rdy[1]), .so(so[1]), .so_vld(sov[1]), .busy(bsy[1]), .done(dn[1]));

  function automatic int gp(int i);
    return i == 0 ? 0 : 3;
  endfunction

  function automatic bit mrdy(int i);
    return q[i].size() == 0 || (gp(i) == 0 && q[i].size() == 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic verify();
    for (int i = 0; i < 2; i++) begin
      ent_t e;
      e = q[i].size() != 0 ? q[i][0] : '0;
      check($sformatf("so%0d", i), so[i], e.b);
      check($sformatf("so_vld%0d", i), sov[i], e.v);
      check($sformatf("done%0d", i), dn[i], e.l);
      check($sformatf("busy%0d", i), bsy[i], q[i].size() != 0);
      check($sformatf("din_rdy%0d", i), rdy[i], rst_n && mrdy(i));
    end
  endtask

  task automatic step(input logic v, input logic [7:0] d);
    logic [1:0] acc;
    din_vld = v;
    din = d;
    for (int i = 0; i < 2; i++) acc[i] = v && rst_n && mrdy(i);
    @(negedge ck);
    for (int i = 0; i < 2; i++) begin
      if (q[i].size() != 0) void'(q[i].pop_front());
      if (acc[i]) begin
        for (int k = 7; k >= 0; k--) q[i].push_back('{d[k], 1'b1, k == 0 && PB == 0});
        if (PB == 1) q[i].push_back('{^d, 1'b1, 1'b1});
        for (int g = 0; g < gp(i); g++) q[i].push_back('0);
      end
    end
    @(posedge ck);
    verify();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 8'($urandom));
  endtask

  initial begin
    repeat (2) begin
      @(posedge ck);
      verify();
    end
    #2 rst_n = 1'b1;
    #1 verify();
    idle(2);
    step(1'b1, 8'hB4);
    idle(10);
    step(1'b1, 8'hFF);
    repeat (8) step(1'b1, 8'h00);
    idle(20);
    step(1'b1, 8'hA5);
    repeat (12) step(1'b1, 8'h3C);
    idle(20);
    step(1'b1, 8'hB5);
    idle(14);
    for (int k = 0; k < 400; k++) step($urandom_range(0, 2) != 0, 8'($urandom));
    idle(20);
    step(1'b1, 8'hB4);
    idle(3);
    #2 rst_n = 1'b0;
    q[0].delete();
    q[1].delete();
    #1 verify();
    @(negedge ck);
    @(posedge ck);
    verify();
    #2 rst_n = 1'b1;
    #1 verify();
    step(1'b1, 8'h80);
    idle(14);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
